// File: rtl/moore_10010_pkg.sv
// Shared constants for the 1-0-0-1-0 Moore sequence detector.
// State codes are fixed; 6 and 7 are illegal and self-recover to S0.
package moore_10010_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    function automatic logic is_legal(input state_t s);
        return s <= S5;
    endfunction

endpackage

// File: rtl/moore_10010.sv
// Moore detector for serial pattern 1-0-0-1-0 (MSB first), overlapping.
// out is decoded from the state register only.
module moore_10010
    import moore_10010_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic in,
    output logic out
);

    state_t cs;
    state_t ns;

    always_comb begin
        ns = S0;
        case (cs)
            S0:      ns = in ? S1 : S0;
            S1:      ns = in ? S1 : S2;
            S2:      ns = in ? S1 : S3;
            S3:      ns = in ? S4 : S0;
            S4:      ns = in ? S1 : S5;
            // trailing "10" of a hit is reused as the next prefix
            S5:      ns = in ? S1 : S3;
            default: ns = S0;
        endcase
    end

    // illegal codes recover even while enable is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs <= S0;
        end else if (enable || !is_legal(cs)) begin
            cs <= ns;
        end
    end

    assign out = (cs == S5);

endmodule

// File: tb/tb_moore_10010.sv
// Self-checking bench for moore_10010: vector table, async-reset
// sequences and a random run against a 5-bit shift-register model.
module tb_moore_10010;

    typedef struct {
        logic rst;
        logic en;
        logic din;
        logic exp;
    } vec_t;

    logic clk;
    logic reset;
    logic enable;
    logic in;
    logic out;

    int errors;
    int checks;

    moore_10010 dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .in     (in),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: out=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic d);
        @(negedge clk);
        reset  = r;
        enable = e;
        in     = d;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic e,
                               input logic d, input logic x);
        vec_t t;
        t.rst = r;
        t.en  = e;
        t.din = d;
        t.exp = x;
        return t;
    endfunction

    logic [4:0] hist;
    logic       exp_out;

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        enable = 1'b1;
        in     = 1'b0;
        #2;
        check("reset_async", out, 1'b0);

        // reset held, then idle zeros
        vecs.push_back(v(1, 1, 1, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(v(0, 1, 0, 0));
        // basic pattern 1 0 0 1 0
        vecs.push_back(v(0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 1));
        // overlap: S5 -0-> S3 -1-> S4 -0-> S5
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 1));
        vecs.push_back(v(0, 1, 1, 0));
        // now S1; go to S4 then hold with enable low
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 1));
        // hold S5
        vecs.push_back(v(0, 0, 1, 1));
        vecs.push_back(v(0, 0, 0, 1));
        vecs.push_back(v(0, 1, 1, 0));
        // S1: 0 0 0 -> S3 -0-> S0, then 1 0 0 1 0
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 1));
        // S5 -1-> S1, then 0 1 : S2 -1-> S1, then 0 0 1 0
        vecs.push_back(v(0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0));
        vecs.push_back(v(0, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 1));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].din);
            check($sformatf("vec%0d", i), out, vecs[i].exp);
        end

        // currently S5: async reset between edges clears out at once
        reset = 1'b1;
        #1;
        check("async_rst_s5", out, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // reach S3 then reset mid-cycle; "10" must not complete a hit
        step(0, 1, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        check("pre_rst_s3", out, 1'b0);
        reset = 1'b1;
        #1;
        check("async_rst_s3", out, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 1);
        check("restart_1", out, 1'b0);
        step(0, 1, 0);
        check("restart_10", out, 1'b0);
        step(0, 1, 0);
        check("restart_100", out, 1'b0);
        step(0, 1, 1);
        check("restart_1001", out, 1'b0);
        step(0, 1, 0);
        check("restart_hit", out, 1'b1);

        // random run against shift-register model
        step(1, 1, 0);
        hist = 5'b0;
        for (int i = 0; i < 1000; i++) begin
            logic e;
            logic d;
            e = ($urandom_range(0, 7) != 0);
            d = 1'($urandom_range(0, 1));
            step(0, e, d);
            if (e) hist = {hist[3:0], d};
            exp_out = (hist == 5'b10010);
            check($sformatf("rand%0d", i), out, exp_out);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
